// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display.
//   - Segment patterns for 0-9, dash and off, bit order {g,f,e,d,c,b,a},
//     active-high (1 = segment lit).
//   - Digit index enum used as the scan position (ones .. thousands).
//   - Packed BCD bundle type and a one-hot digit-enable helper.
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    DIG_ONES      = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_idx_t;

  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd4_t;

  // One-hot anode pattern for a scan position, active-high.
  function automatic logic [3:0] digit_enable(input digit_idx_t idx);
    logic [3:0] en;
    en = '0;
    en[idx] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-high output.
//   digit : 4-bit digit value; 0-9 decode normally, 10-15 show a dash
//   blank : forces all segments off (takes priority over digit)
//   seg   : segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_mux.sv
// Four-digit time-multiplexed 7-segment display driver.
//   clk, reset  : single clock, synchronous active-high reset
//   load        : one-cycle strobe capturing thousands/hundreds/tens/ones
//   thousands.. : BCD digit inputs
//   blank_lz    : leading-zero blanking enable, used live
//   seg         : registered segments {g,f,e,d,c,b,a}
//   an          : registered one-hot digit enables, an[0] = ones
//   frame_done  : one-cycle pulse when a new 4-digit scan begins
// Parameters: REFRESH_DIV clocks per digit slot (>= 2); ACTIVE_LOW inverts
// seg and an so that 0 means lit/enabled.
module display_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic        ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned     CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_INV = {7{ACTIVE_LOW}};
  localparam logic [3:0]      AN_INV  = {4{ACTIVE_LOW}};

  if (REFRESH_DIV < 2) begin : g_div_check
    $error("display_mux: REFRESH_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             frame_end;
  digit_idx_t       idx;
  digit_idx_t       idx_next;
  bcd4_t            live;
  bcd4_t            pend;
  logic             pend_valid;
  bcd4_t            disp;
  bcd4_t            disp_next;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic [6:0]       seg_raw;
  logic [3:0]       an_raw;

  assign live      = '{thousands: thousands, hundreds: hundreds,
                       tens: tens, ones: ones};
  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (idx == DIG_THOUSANDS);

  // Slot prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan position: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= DIG_ONES;
    end else begin
      idx <= idx_next;
    end
  end

  // Scan position: next state.
  always_comb begin
    idx_next = idx;
    if (tick) begin
      case (idx)
        DIG_ONES:      idx_next = DIG_TENS;
        DIG_TENS:      idx_next = DIG_HUNDREDS;
        DIG_HUNDREDS:  idx_next = DIG_THOUSANDS;
        DIG_THOUSANDS: idx_next = DIG_ONES;
        default:       idx_next = DIG_ONES;
      endcase
    end
  end

  // Display contents only change at frame end. A load landing exactly on
  // frame end bypasses the pending buffer; otherwise it parks there.
  always_comb begin
    disp_next = disp;
    if (frame_end) begin
      if (load) begin
        disp_next = live;
      end else if (pend_valid) begin
        disp_next = pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp <= disp_next;
      if (frame_end) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend       <= live;
        pend_valid <= 1'b1;
      end
    end
  end

  // Scan position: outputs. Built from the next-state values so the
  // registered seg/an track the new slot (and new frame contents) on the
  // same edge that moves the scan.
  always_comb begin
    cur_digit = disp_next.ones;
    cur_blank = 1'b0;
    case (idx_next)
      DIG_ONES: begin
        cur_digit = disp_next.ones;
        cur_blank = 1'b0;
      end
      DIG_TENS: begin
        cur_digit = disp_next.tens;
        cur_blank = blank_lz && (disp_next.thousands == 4'd0)
                    && (disp_next.hundreds == 4'd0) && (disp_next.tens == 4'd0);
      end
      DIG_HUNDREDS: begin
        cur_digit = disp_next.hundreds;
        cur_blank = blank_lz && (disp_next.thousands == 4'd0)
                    && (disp_next.hundreds == 4'd0);
      end
      DIG_THOUSANDS: begin
        cur_digit = disp_next.thousands;
        cur_blank = blank_lz && (disp_next.thousands == 4'd0);
      end
      default: begin
        cur_digit = disp_next.ones;
        cur_blank = 1'b0;
      end
    endcase
    an_raw = digit_enable(idx_next);
  end

  seg7_decode u_decode (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_INV;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_raw ^ SEG_INV;
      an         <= an_raw ^ AN_INV;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux with REFRESH_DIV=4, ACTIVE_LOW=0.
// Stimulus pushes the expected contents of each upcoming frame; a monitor
// pops one entry per frame_done and checks every digit slot of that frame.
module tb_display_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] thousands, hundreds, tens, ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  display_mux #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .thousands  (thousands),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][6:0] segs;   // index 0 = ones ... 3 = thousands
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cycle    = 0;
  logic   mon_en   = 1'b0;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    frame_t f;
    f.segs[3] = s3;
    f.segs[2] = s2;
    f.segs[1] = s1;
    f.segs[0] = s0;
    exp_q.push_back(f);
  endtask

  // One-cycle load strobe, starting at the current negedge.
  task automatic do_load(input logic [3:0] t, input logic [3:0] h,
                         input logic [3:0] te, input logic [3:0] o);
    thousands = t; hundreds = h; tens = te; ones = o;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    if (!frame_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: frame_done absent for 40 cycles, expected a pulse");
    end
  endtask

  // Monitor: one expected frame per frame_done, four slots 4 clocks apart.
  initial begin
    int     frame_no;
    int     prev_cycle;
    logic   have_prev;
    frame_t fr;
    logic [3:0] oh;
    frame_no  = 0;
    have_prev = 1'b0;
    prev_cycle = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        have_prev = 1'b0;
      end else if (frame_done) begin
        frame_no++;
        if (have_prev)
          check($sformatf("frame%0d_period", frame_no), 32'(cycle - prev_cycle), 32'd16);
        prev_cycle = cycle;
        have_prev  = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL frame%0d_unexpected: got frame_done, expected none", frame_no);
        end else begin
          fr = exp_q.pop_front();
          for (int s = 0; s < 4; s++) begin
            if (s != 0) repeat (4) @(negedge clk);
            if (!mon_en) break;
            oh = 4'(1 << s);
            check($sformatf("frame%0d_slot%0d_an_seg", frame_no, s),
                  32'({an, seg}), 32'({oh, fr.segs[s]}));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);

    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);          // F1: 0000
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_reset_an", 32'(an), 32'h1);
    check("post_reset_seg", 32'(seg), 32'h3F);

    wait_frame();                                    // F1 shown
    repeat (5) @(negedge clk);
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66);          // F2: 1234

    wait_frame();                                    // F2 shown
    blank_lz = 1'b1;
    repeat (5) @(negedge clk);
    do_load(4'd0, 4'd0, 4'd7, 4'd0);
    push_frame(7'h00, 7'h00, 7'h07, 7'h3F);          // F3: __70

    wait_frame();                                    // F3 shown
    repeat (5) @(negedge clk);
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    push_frame(7'h00, 7'h00, 7'h00, 7'h3F);          // F4: ___0

    wait_frame();                                    // F4 shown
    repeat (2) @(negedge clk);
    do_load(4'd5, 4'd5, 4'd5, 4'd5);
    repeat (3) @(negedge clk);
    do_load(4'd9, 4'd9, 4'd9, 4'd9);
    push_frame(7'h6F, 7'h6F, 7'h6F, 7'h6F);          // F5: 9999
    repeat (8) @(negedge clk);
    blank_lz = 1'b0;                                 // frame-end cycle of F4

    wait_frame();                                    // F5 shown
    repeat (15) @(negedge clk);                      // frame-end cycle of F5
    thousands = 4'd8; hundreds = 4'd0; tens = 4'd0; ones = 4'd1;
    load = 1'b1;
    push_frame(7'h7F, 7'h3F, 7'h3F, 7'h06);          // F6: 8001
    wait_frame();                                    // F6 shown
    load = 1'b0;
    push_frame(7'h7F, 7'h3F, 7'h3F, 7'h06);          // F7: unchanged

    wait_frame();                                    // F7 shown
    repeat (5) @(negedge clk);
    do_load(4'd0, 4'd0, 4'd0, 4'hC);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h40);          // F8: 000-

    wait_frame();                                    // F8 shown
    @(negedge clk);
    mon_en = 1'b0;
    do_load(4'd1, 4'd2, 4'd3, 4'd4);                 // pending, then reset
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_reset_an", 32'(an), 32'h0);
    check("mid_reset_frame_done", 32'(frame_done), 32'h0);
    exp_q.delete();
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);          // F9: 0000
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_reset2_an", 32'(an), 32'h1);
    check("post_reset2_seg", 32'(seg), 32'h3F);

    wait_frame();                                    // F9 shown
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);          // F10: still 0000
    wait_frame();                                    // F10 shown
    repeat (14) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
